// File: rtl/axi_lite_arb2.sv
// Two-master AXI-lite arbiter in front of a single shared AXI-lite slave port.
// One transaction in flight at a time; round-robin between masters, writes first.
module axi_lite_arb2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                areset_n,
    // master 0
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    output logic [1:0]          m0_bresp,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    // master 1
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [1:0]          m1_bresp,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    // shared slave port
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [1:0]          s_bresp,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    // status
    output logic [1:0]          grant,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR_XFER,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic sel;
    logic in_wx, in_wr, in_ra, in_rd;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic req0, req1, pick;

    assign sel   = grant_q[1];
    assign in_wx = (state_q == WR_XFER);
    assign in_wr = (state_q == WR_RESP);
    assign in_ra = (state_q == RD_ADDR);
    assign in_rd = (state_q == RD_DATA);

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign b_hs  = s_bvalid && s_bready;
    assign ar_hs = s_arvalid && s_arready;
    assign r_hs  = s_rvalid && s_rready;

    assign req0 = m0_awvalid || m0_arvalid;
    assign req1 = m1_awvalid || m1_arvalid;

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

    // Pure mux forwarding selected by the grant register, gated by phase.
    always_comb begin
        s_awaddr   = sel ? m1_awaddr : m0_awaddr;
        s_wdata    = sel ? m1_wdata  : m0_wdata;
        s_wstrb    = sel ? m1_wstrb  : m0_wstrb;
        s_araddr   = sel ? m1_araddr : m0_araddr;
        s_awvalid  = in_wx && !aw_done_q && (sel ? m1_awvalid : m0_awvalid);
        s_wvalid   = in_wx && !w_done_q && (sel ? m1_wvalid : m0_wvalid);
        s_bready   = in_wr && (sel ? m1_bready : m0_bready);
        s_arvalid  = in_ra && (sel ? m1_arvalid : m0_arvalid);
        s_rready   = in_rd && (sel ? m1_rready : m0_rready);
        m0_awready = grant_q[0] && in_wx && !aw_done_q && s_awready;
        m0_wready  = grant_q[0] && in_wx && !w_done_q && s_wready;
        m0_bvalid  = grant_q[0] && in_wr && s_bvalid;
        m0_arready = grant_q[0] && in_ra && s_arready;
        m0_rvalid  = grant_q[0] && in_rd && s_rvalid;
        m1_awready = grant_q[1] && in_wx && !aw_done_q && s_awready;
        m1_wready  = grant_q[1] && in_wx && !w_done_q && s_wready;
        m1_bvalid  = grant_q[1] && in_wr && s_bvalid;
        m1_arready = grant_q[1] && in_ra && s_arready;
        m1_rvalid  = grant_q[1] && in_rd && s_rvalid;
        m0_bresp   = s_bresp;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m1_bresp   = s_bresp;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
    end

    // Arbitration in IDLE and phase sequencing of the single transaction.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        pick      = 1'b0;
        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (req0 || req1) begin
                    pick    = (req0 && req1) ? !last_q : req1;
                    grant_d = pick ? 2'b10 : 2'b01;
                    last_d  = pick;
                    if (pick ? m1_awvalid : m0_awvalid) begin
                        state_d = WR_XFER;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR_XFER: begin
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d   = IDLE;
                    grant_d   = 2'b00;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State registers; last pointer resets to master 1 so master 0 wins first tie.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Bench for axi_lite_arb2: scenario tasks plus randomized traffic
// checked against a byte-strobe memory model and a grant-trace summary.
module tb_axi_lite_arb2;

    logic aclk = 1'b0;
    logic areset_n = 1'b1;
    always #5 aclk = ~aclk;

    logic        m_awvalid[2], m_awready[2];
    logic [31:0] m_awaddr[2];
    logic        m_wvalid[2], m_wready[2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_wstrb[2];
    logic        m_bvalid[2], m_bready[2];
    logic [1:0]  m_bresp[2];
    logic        m_arvalid[2], m_arready[2];
    logic [31:0] m_araddr[2];
    logic        m_rvalid[2], m_rready[2];
    logic [31:0] m_rdata[2];
    logic [1:0]  m_rresp[2];

    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic        s_bvalid, s_bready, s_arvalid, s_arready;
    logic        s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic [1:0]  grant;
    logic        busy;

    axi_lite_arb2 #(.ADDR_W(32), .DATA_W(32)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_awaddr(m_awaddr[0]),
        .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_wdata(m_wdata[0]),
        .m0_wstrb(m_wstrb[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
        .m0_bresp(m_bresp[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
        .m0_araddr(m_araddr[0]), .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
        .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]),
        .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_awaddr(m_awaddr[1]),
        .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_wdata(m_wdata[1]),
        .m1_wstrb(m_wstrb[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
        .m1_bresp(m_bresp[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
        .m1_araddr(m_araddr[1]), .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
        .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .grant(grant), .busy(busy)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // reference model: expected memory contents as seen by the masters
    logic [31:0] model_mem[logic [31:0]];

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 32'h0;
    endfunction

    // grant trace, summarised as "seg/gap/seg..." (gap = idle cycles between grants)
    bit         trace_on = 0;
    bit         chk_inv = 0;
    logic [1:0] gtrace[$];

    function automatic string seg_str();
        string      s;
        logic [1:0] prev;
        int         zeros;
        bit         started;
        s = "";
        prev = 2'b00;
        zeros = 0;
        started = 0;
        foreach (gtrace[i]) begin
            if (gtrace[i] != 2'b00) begin
                if (prev == 2'b00 || gtrace[i] != prev) begin
                    if (started) s = {s, $sformatf("/%0d/", zeros)};
                    s = {s, $sformatf("%b", gtrace[i])};
                    started = 1;
                end
                zeros = 0;
            end else begin
                zeros++;
            end
            prev = gtrace[i];
        end
        return s;
    endfunction

    always @(negedge aclk) begin
        if (trace_on) gtrace.push_back(grant);
        if (chk_inv) begin
            total++;
            if (grant == 2'b11 || busy !== (grant != 2'b00)) begin
                bad++;
                $display("FAIL grant_busy_inv got grant=%b busy=%b want onehot/idle consistent",
                         grant, busy);
            end
        end
    end

    // shared-port slave (bridge) environment
    bit          rand_mode = 0;
    int          aw_stall = 0;
    bit          b_hold = 0;
    bit          force_r = 0;
    logic [31:0] force_rdata = 32'h0;
    logic [1:0]  force_rresp = 2'b00;
    logic [31:0] smem[logic [31:0]];
    int cnt_aw = 0, cnt_w = 0, cnt_b = 0, wv_cycles = 0;
    int aw_cyc = 0, w_cyc = 0;

    initial begin
        bit awh, wh, bh, arh, rh, got_aw, got_w;
        logic [31:0] la, ld, lr;
        logic [3:0]  ls;
        got_aw = 0; got_w = 0;
        la = 0; ld = 0; lr = 0; ls = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        forever begin
            @(negedge aclk);
            awh = s_awvalid && s_awready;
            wh  = s_wvalid && s_wready;
            bh  = s_bvalid && s_bready;
            arh = s_arvalid && s_arready;
            rh  = s_rvalid && s_rready;
            if (s_wvalid) wv_cycles++;
            if (s_awvalid && !s_awready && aw_stall > 0) aw_stall--;
            if (awh) begin cnt_aw++; aw_cyc = cyc; la = s_awaddr; end
            if (wh) begin cnt_w++; w_cyc = cyc; ld = s_wdata; ls = s_wstrb; end
            if (bh) cnt_b++;
            if (arh) lr = s_araddr;
            @(posedge aclk);
            #1;
            if (!areset_n) begin
                got_aw = 0; got_w = 0;
                s_awready = 0; s_wready = 0; s_bvalid = 0;
                s_arready = 0; s_rvalid = 0;
                continue;
            end
            if (awh) got_aw = 1;
            if (wh) got_w = 1;
            if (bh) s_bvalid = 0;
            if (got_aw && got_w && !s_bvalid && !b_hold) begin
                smem[la] = merge(smem.exists(la) ? smem[la] : 32'h0, ld, ls);
                s_bvalid = 1;
                s_bresp = 2'b00;
                got_aw = 0;
                got_w = 0;
            end
            s_awready = !got_aw && aw_stall == 0 && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
            s_wready  = !got_w && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
            if (rh) s_rvalid = 0;
            if (arh) begin
                s_rvalid = 1;
                s_rdata  = force_r ? force_rdata : (smem.exists(lr) ? smem[lr] : 32'h0);
                s_rresp  = force_r ? force_rresp : 2'b00;
            end
            s_arready = !s_rvalid && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp, output bit ok);
        bit awf, wf, bf;
        @(posedge aclk);
        #1;
        m_awvalid[m] = 1; m_awaddr[m] = a;
        m_wvalid[m] = 1; m_wdata[m] = d; m_wstrb[m] = s;
        m_bready[m] = 1;
        ok = 0;
        resp = 2'bxx;
        for (int n = 0; n < 400; n++) begin
            @(negedge aclk);
            awf = m_awvalid[m] && m_awready[m];
            wf  = m_wvalid[m] && m_wready[m];
            bf  = m_bvalid[m] && m_bready[m];
            if (bf) resp = m_bresp[m];
            @(posedge aclk);
            #1;
            if (awf) m_awvalid[m] = 0;
            if (wf) m_wvalid[m] = 0;
            if (bf) begin m_bready[m] = 0; ok = 1; break; end
        end
        if (!ok) begin m_awvalid[m] = 0; m_wvalid[m] = 0; m_bready[m] = 0; end
    endtask

    task automatic do_read(input int m, input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output bit ok);
        bit arf, rf;
        @(posedge aclk);
        #1;
        m_arvalid[m] = 1; m_araddr[m] = a; m_rready[m] = 1;
        ok = 0;
        d = 32'hx;
        resp = 2'bxx;
        for (int n = 0; n < 400; n++) begin
            @(negedge aclk);
            arf = m_arvalid[m] && m_arready[m];
            rf  = m_rvalid[m] && m_rready[m];
            if (rf) begin d = m_rdata[m]; resp = m_rresp[m]; end
            @(posedge aclk);
            #1;
            if (arf) m_arvalid[m] = 0;
            if (rf) begin m_rready[m] = 0; ok = 1; break; end
        end
        if (!ok) begin m_arvalid[m] = 0; m_rready[m] = 0; end
    endtask

    task automatic test_reset();
        for (int m = 0; m < 2; m++) begin
            m_awvalid[m] = 0; m_awaddr[m] = 0; m_wvalid[m] = 0; m_wdata[m] = 0;
            m_wstrb[m] = 0; m_bready[m] = 0; m_arvalid[m] = 0; m_araddr[m] = 0;
            m_rready[m] = 0;
        end
        #1 areset_n = 0;
        repeat (2) @(negedge aclk);
        total++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got grant=%b busy=%b want 00/0", grant, busy);
        end
        total++;
        if ({s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} !== 5'b0 ||
            {m_awready[0], m_wready[0], m_bvalid[0], m_arready[0], m_rvalid[0],
             m_awready[1], m_wready[1], m_bvalid[1], m_arready[1], m_rvalid[1]} !== 10'b0) begin
            bad++;
            $display("FAIL reset_hs got s=%b want all handshake outputs 0",
                     {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready});
        end
        #2 areset_n = 1;
        repeat (2) @(negedge aclk);
        total++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle got grant=%b busy=%b want 00/0", grant, busy);
        end
    endtask

    task automatic test_tie(input string tag);
        logic [1:0] r0, r1;
        bit ok0, ok1;
        string s;
        gtrace.delete();
        trace_on = 1;
        fork
            do_write(0, 32'h100, 32'h1111_0000, 4'hF, r0, ok0);
            do_write(1, 32'h200, 32'h2222_0001, 4'hF, r1, ok1);
        join
        repeat (2) @(negedge aclk);
        trace_on = 0;
        model_mem[32'h100] = 32'h1111_0000;
        model_mem[32'h200] = 32'h2222_0001;
        s = seg_str();
        total++;
        if (s != "01/1/10") begin
            bad++;
            $display("FAIL %s_grant_seq got %s want 01/1/10", tag, s);
        end
        total++;
        if (!(ok0 && ok1) || r0 !== 2'b00 || r1 !== 2'b00) begin
            bad++;
            $display("FAIL %s_bresp got ok=%b%b r0=%b r1=%b want 11/00/00", tag, ok0, ok1, r0, r1);
        end
    endtask

    task automatic test_wr_rd_order();
        bit awf, wf, bf, arf, rf, bdone, rdone;
        logic [1:0] br, rr;
        logic [31:0] rd;
        string s;
        br = 2'bxx; rr = 2'bxx; rd = 32'hx;
        bdone = 0; rdone = 0;
        gtrace.delete();
        trace_on = 1;
        @(posedge aclk);
        #1;
        m_awvalid[0] = 1; m_awaddr[0] = 32'h1000_0010;
        m_wvalid[0] = 1; m_wdata[0] = 32'hA5A5_0001; m_wstrb[0] = 4'hF;
        m_bready[0] = 1;
        m_arvalid[0] = 1; m_araddr[0] = 32'h1000_0010; m_rready[0] = 1;
        for (int n = 0; n < 200 && !(bdone && rdone); n++) begin
            @(negedge aclk);
            awf = m_awvalid[0] && m_awready[0];
            wf  = m_wvalid[0] && m_wready[0];
            bf  = m_bvalid[0] && m_bready[0];
            arf = m_arvalid[0] && m_arready[0];
            rf  = m_rvalid[0] && m_rready[0];
            if (bf) br = m_bresp[0];
            if (rf) begin rd = m_rdata[0]; rr = m_rresp[0]; end
            @(posedge aclk);
            #1;
            if (awf) m_awvalid[0] = 0;
            if (wf) m_wvalid[0] = 0;
            if (bf) begin m_bready[0] = 0; bdone = 1; end
            if (arf) m_arvalid[0] = 0;
            if (rf) begin m_rready[0] = 0; rdone = 1; end
        end
        m_awvalid[0] = 0; m_wvalid[0] = 0; m_bready[0] = 0;
        m_arvalid[0] = 0; m_rready[0] = 0;
        repeat (2) @(negedge aclk);
        trace_on = 0;
        model_mem[32'h1000_0010] = 32'hA5A5_0001;
        s = seg_str();
        total++;
        if (!bdone || br !== 2'b00) begin
            bad++;
            $display("FAIL wr_first_bresp got done=%b bresp=%b want 1/00", bdone, br);
        end
        total++;
        if (!rdone || rd !== 32'hA5A5_0001 || rr !== 2'b00) begin
            bad++;
            $display("FAIL wr_before_rd_data got %h/%b want a5a50001/00", rd, rr);
        end
        total++;
        if (s != "01/1/01") begin
            bad++;
            $display("FAIL wr_rd_grant_seq got %s want 01/1/01", s);
        end
    endtask

    task automatic test_w_before_aw();
        int a0, w0, b0, v0;
        logic [1:0] r;
        logic [31:0] d;
        bit ok;
        a0 = cnt_aw; w0 = cnt_w; b0 = cnt_b; v0 = wv_cycles;
        @(posedge aclk);
        #2 aw_stall = 3;
        do_write(0, 32'h108, 32'h0BAD_F00D, 4'hF, r, ok);
        model_mem[32'h108] = 32'h0BAD_F00D;
        total++;
        if (!ok || r !== 2'b00) begin
            bad++;
            $display("FAIL w_early_bresp got ok=%b bresp=%b want 1/00", ok, r);
        end
        total++;
        if (cnt_aw - a0 != 1 || cnt_w - w0 != 1 || cnt_b - b0 != 1) begin
            bad++;
            $display("FAIL w_early_counts got aw=%0d w=%0d b=%0d want 1/1/1",
                     cnt_aw - a0, cnt_w - w0, cnt_b - b0);
        end
        total++;
        if (aw_cyc - w_cyc != 3) begin
            bad++;
            $display("FAIL w_early_gap got %0d want 3", aw_cyc - w_cyc);
        end
        total++;
        if (wv_cycles - v0 != 1) begin
            bad++;
            $display("FAIL w_valid_masked got %0d cycles want 1", wv_cycles - v0);
        end
        do_read(1, 32'h108, d, r, ok);
        total++;
        if (!ok || d !== model_rd(32'h108)) begin
            bad++;
            $display("FAIL w_early_readback got %h want %h", d, model_rd(32'h108));
        end
    endtask

    task automatic test_back_to_back();
        bit arf, rf;
        int nar, nr, errs;
        logic [31:0] got[4];
        string s;
        nar = 0; nr = 0; errs = 0;
        gtrace.delete();
        trace_on = 1;
        @(posedge aclk);
        #1;
        m_arvalid[1] = 1; m_araddr[1] = 32'h200; m_rready[1] = 1;
        for (int n = 0; n < 300 && nr < 4; n++) begin
            @(negedge aclk);
            arf = m_arvalid[1] && m_arready[1];
            rf  = m_rvalid[1] && m_rready[1];
            if (rf) got[nr] = m_rdata[1];
            @(posedge aclk);
            #1;
            if (arf) begin
                nar++;
                if (nar == 4) m_arvalid[1] = 0;
                else m_araddr[1] = 32'h200 + 32'(4 * nar);
            end
            if (rf) nr++;
        end
        m_arvalid[1] = 0; m_rready[1] = 0;
        repeat (2) @(negedge aclk);
        trace_on = 0;
        s = seg_str();
        total++;
        if (s != "10/1/10/1/10/1/10") begin
            bad++;
            $display("FAIL b2b_grant_seq got %s want 10/1/10/1/10/1/10", s);
        end
        for (int i = 0; i < nr; i++)
            if (got[i] !== model_rd(32'h200 + 32'(4 * i))) errs++;
        total++;
        if (nr != 4 || errs != 0) begin
            bad++;
            $display("FAIL b2b_rdata got reads=%0d errs=%0d want 4/0", nr, errs);
        end
    endtask

    task automatic test_rresp();
        logic [31:0] d;
        logic [1:0] r;
        bit ok;
        force_r = 1;
        force_rdata = 32'hDEAD_BEEF;
        force_rresp = 2'b10;
        do_read(0, 32'h104, d, r, ok);
        force_r = 0;
        total++;
        if (!ok || d !== 32'hDEAD_BEEF || r !== 2'b10) begin
            bad++;
            $display("FAIL slverr_pass got %h/%b want deadbeef/10", d, r);
        end
    endtask

    task automatic master_rand(input int m, input int nops);
        logic [31:0] a, d, got;
        logic [3:0] st;
        logic [1:0] r;
        bit ok;
        for (int k = 0; k < nops; k++) begin
            a = (m == 0 ? 32'h1000 : 32'h2000) + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                st = 4'($urandom_range(1, 15));
                do_write(m, a, d, st, r, ok);
                model_mem[a] = merge(model_rd(a), d, st);
                total++;
                if (!ok || r !== 2'b00) begin
                    bad++;
                    $display("FAIL rand_wr m%0d a=%h got ok=%b bresp=%b want 1/00", m, a, ok, r);
                end
            end else begin
                do_read(m, a, got, r, ok);
                total++;
                if (!ok || got !== model_rd(a) || r !== 2'b00) begin
                    bad++;
                    $display("FAIL rand_rd m%0d a=%h got %h want %h", m, a, got, model_rd(a));
                end
            end
            repeat ($urandom_range(0, 2)) @(posedge aclk);
        end
    endtask

    task automatic test_random();
        rand_mode = 1;
        chk_inv = 1;
        fork
            master_rand(0, 20);
            master_rand(1, 20);
        join
        chk_inv = 0;
        rand_mode = 0;
        repeat (3) @(posedge aclk);
    endtask

    task automatic test_reset_mid();
        bit awf, wf, in_resp;
        int quiet;
        in_resp = 0;
        b_hold = 1;
        @(posedge aclk);
        #1;
        m_awvalid[0] = 1; m_awaddr[0] = 32'h300;
        m_wvalid[0] = 1; m_wdata[0] = 32'h3333_3333; m_wstrb[0] = 4'hF;
        m_bready[0] = 1;
        for (int n = 0; n < 60; n++) begin
            @(negedge aclk);
            if (s_bready) begin in_resp = 1; break; end
            awf = m_awvalid[0] && m_awready[0];
            wf  = m_wvalid[0] && m_wready[0];
            @(posedge aclk);
            #1;
            if (awf) m_awvalid[0] = 0;
            if (wf) m_wvalid[0] = 0;
        end
        total++;
        if (!in_resp || grant !== 2'b01 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reach_wr_resp got resp=%b grant=%b busy=%b want 1/01/1",
                     in_resp, grant, busy);
        end
        #2 areset_n = 0;
        #1;
        total++;
        if (grant !== 2'b00 || busy !== 1'b0 || s_bready !== 1'b0 ||
            m_bvalid[0] !== 1'b0 || s_awvalid !== 1'b0 || s_wvalid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got grant=%b busy=%b bready=%b want 00/0/0",
                     grant, busy, s_bready);
        end
        m_awvalid[0] = 0; m_wvalid[0] = 0; m_bready[0] = 0;
        b_hold = 0;
        repeat (2) @(negedge aclk);
        #2 areset_n = 1;
        m_bready[0] = 1;
        quiet = 0;
        repeat (4) begin
            @(negedge aclk);
            if (m_bvalid[0] || busy || s_bvalid) quiet++;
        end
        m_bready[0] = 0;
        total++;
        if (quiet != 0) begin
            bad++;
            $display("FAIL no_replay got %0d active cycles want 0", quiet);
        end
        test_tie("post_rst");
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tie("tie");
        test_wr_rd_order();
        test_w_before_aw();
        test_back_to_back();
        test_rresp();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_arb2.md
AXI_LITE_ARB2 -- requirements
Module: axi_lite_arb2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all AW/AR channels.
REQ-002 SHALL have parameter DATA_W, default 32, data width of all W/R channels; strobe width DATA_W/8.
REQ-003 SHALL have port aclk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port areset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports m0_aw{valid,ready,addr}, m0_w{valid,ready,data,strb}, m0_b{valid,ready,resp}: AXI-lite slave-side write channels for master 0 (valid/data in, ready out; b valid/resp out, ready in).
REQ-006 SHALL have ports m0_ar{valid,ready,addr}, m0_r{valid,ready,data,resp}: AXI-lite slave-side read channels for master 0.
REQ-007 SHALL have the identical port set prefixed m1_ for master 1.
REQ-008 SHALL have ports s_aw*, s_w*, s_b*, s_ar*, s_r*: AXI-lite master-side channels toward the shared AXI-to-APB bridge, mirrored directions.
REQ-009 SHALL have port grant  output  2  one-hot owner of the shared port, 2'b00 when idle.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, WR_XFER, WR_RESP, RD_ADDR, RD_DATA.
REQ-012 Master request SHALL be mN_awvalid | mN_arvalid, sampled only in IDLE.
REQ-013 Arbitration SHALL be round-robin: if both request, grant the master not granted last; if one requests, grant it regardless of history.
REQ-014 Within the granted master, write SHALL win over read when awvalid and arvalid are both high (store-before-load ordering).
REQ-015 Grant SHALL register at the IDLE clock edge; first forwarded valid appears on s_* in the following cycle (1-cycle arbitration bubble).
REQ-016 WR_XFER SHALL forward AW and W of the granted master combinationally and independently; sticky aw_done/w_done flags SHALL record each handshake, and the completed channel's valid to s_* SHALL be masked after its handshake.
REQ-017 WR_XFER -> WR_RESP when both flags set (same cycle allowed); flags cleared on entry to IDLE.
REQ-018 WR_RESP SHALL forward s_bvalid/s_bresp to the granted master and its bready to s_bready; on B handshake -> IDLE.
REQ-019 RD_ADDR SHALL forward AR; on AR handshake -> RD_DATA; RD_DATA SHALL forward R; on R handshake -> IDLE.
REQ-020 Non-granted master SHALL see all ready/valid outputs 0; all s_* valids/readys SHALL be 0 in IDLE.
REQ-021 Data, addr, strb, resp SHALL pass unmodified; forwarding paths SHALL be pure muxes of the grant register (no extra latency).
REQ-022 Exactly one transaction SHALL be outstanding; next arbitration occurs in the IDLE cycle after the final handshake (minimum 1 idle cycle between transactions).
REQ-023 Last-grant pointer SHALL update only when a grant is issued.
REQ-024 A master dropping valid before handshake is a protocol violation; the block SHALL not return to IDLE until the transaction completes.

Reset
REQ-025 On areset_n low, asynchronously: state IDLE, grant 2'b00, busy 0, aw_done/w_done 0, last-grant pointer = master 1 (so master 0 wins first tie).
REQ-026 Reset asserted mid-transaction SHALL abandon it with all s_* and mN_* valid/ready outputs 0 immediately; no response SHALL be replayed after release.

Verification
REQ-027 Both masters assert awvalid same cycle after reset -> grant 2'b01 first; after m0 B handshake, 1 idle cycle, then grant 2'b10.
REQ-028 m0 awvalid+arvalid both high, addr 0x1000_0010 write data 0xA5A5_0001 -> write to s_ completes with bresp 2'b00, then read granted in a later arbitration.
REQ-029 W handshake 3 cycles before AW handshake -> s_wvalid masked after W, single WR_RESP entry, exactly one s_ AW and one W handshake.
REQ-030 m1 issues 4 back-to-back reads while m0 idle -> 4 consecutive grants to m1, each separated by exactly 1 IDLE cycle.
REQ-031 Bridge returns s_rresp 2'b10 (PSLVERR), rdata 0xDEAD_BEEF -> granted master receives rresp 2'b10 and data 0xDEAD_BEEF unchanged.
REQ-032 Reset pulsed while in WR_RESP -> grant 0, busy 0 asynchronously; after release, m0/m1 tie grants m0.
